pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with flush, hazard hold
// and saturating stall/flush statistics counters.
module pipe_stage_reg #(
    parameter int                DATA_W     = 64,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_fire, out_fire;
    logic [1:0]        held_cnt;
    logic [1:0]        flush_inc;
    logic [CNT_W:0]    flush_sum;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    // Handshake outputs come straight from the state register.
    assign in_ready_o  = (state != SKID);
    assign out_valid_o = (state != EMPTY);
    assign out_data_o  = main_q;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i & ~hold_i;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush_i) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE_VAL;
            skid_nxt  = BUBBLE_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = FULL;
                        main_nxt  = in_data_i;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data_i;
                    end else if (in_fire) begin
                        state_nxt = SKID;
                        skid_nxt  = in_data_i;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        main_nxt  = BUBBLE_VAL;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_nxt = FULL;
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = BUBBLE_VAL;
                    skid_nxt  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Entries lost to a flush: everything held plus an accepted input, less
    // whatever the downstream still took this cycle.
    always_comb begin
        held_cnt  = 2'd0;
        flush_inc = 2'd0;
        case (state)
            FULL:    held_cnt = 2'd1;
            SKID:    held_cnt = 2'd2;
            default: held_cnt = 2'd0;
        endcase
        if (flush_i) begin
            flush_inc = held_cnt + {1'b0, in_fire} - {1'b0, out_fire};
        end
        flush_sum = {1'b0, flush_cnt} + (CNT_W + 1)'(flush_inc);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid_o && !out_fire && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_sum > {1'b0, CNT_MAX}) begin
                flush_cnt <= CNT_MAX;
            end else begin
                flush_cnt <= flush_sum[CNT_W-1:0];
            end
        end
    end

endmodule
